// File: rtl/fir_output_buffer.sv
// Output stage behind the FIR filter: decimates the sample stream and buffers kept
// samples in a first-word-fall-through FIFO with a valid/ready drain port.
module fir_output_buffer #(
    parameter int unsigned DATABITS = 16,
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned DECIMW   = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATABITS-1:0]     data_in,
    input  logic                    data_valid_in,
    input  logic [DECIMW-1:0]       decim_in,
    input  logic                    clear_in,
    input  logic                    ready_in,
    output logic [DATABITS-1:0]     data_out,
    output logic                    valid_out,
    output logic [$clog2(DEPTH):0]  level_out,
    output logic                    overflow_out
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [DATABITS-1:0] mem [DEPTH];
    logic [PW-1:0]       wr_ptr, rd_ptr;
    logic [PW-1:0]       wr_ptr_next, rd_ptr_next, level_next;
    logic [DECIMW-1:0]   cnt, cnt_next, eff;
    logic [DECIMW:0]     cnt_inc;
    logic [DATABITS-1:0] data_next;
    logic                kept, full, pop, push, drop;

    // Decimation: keep the sample when the counter sits at zero; >= compare
    // keeps the counter in range if the factor is lowered mid-run.
    always_comb begin
        eff      = (decim_in == '0) ? DECIMW'(1) : decim_in;
        cnt_inc  = (DECIMW+1)'(cnt) + (DECIMW+1)'(1);
        kept     = data_valid_in && (cnt == '0);
        cnt_next = cnt;
        if (data_valid_in) begin
            cnt_next = (cnt_inc >= {1'b0, eff}) ? '0 : cnt_inc[DECIMW-1:0];
        end
    end

    // FIFO control and next head-of-queue value for the registered output.
    always_comb begin
        full        = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        pop         = valid_out && ready_in;
        push        = kept && (!full || pop);
        drop        = kept && full && !pop;
        wr_ptr_next = push ? wr_ptr + PW'(1) : wr_ptr;
        rd_ptr_next = pop  ? rd_ptr + PW'(1) : rd_ptr;

        level_next = level_out;
        if (push && !pop) begin
            level_next = level_out + PW'(1);
        end else if (pop && !push) begin
            level_next = level_out - PW'(1);
        end

        // The entry being written this edge becomes the head only when it is
        // the sole occupant afterwards; bypass the memory for that case.
        data_next = '0;
        if (wr_ptr_next != rd_ptr_next) begin
            if (push && (rd_ptr_next == wr_ptr)) begin
                data_next = data_in;
            end else begin
                data_next = mem[rd_ptr_next[AW-1:0]];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear_in) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            level_out    <= '0;
            cnt          <= '0;
            overflow_out <= 1'b0;
            valid_out    <= 1'b0;
            data_out     <= '0;
        end else begin
            wr_ptr       <= wr_ptr_next;
            rd_ptr       <= rd_ptr_next;
            level_out    <= level_next;
            cnt          <= cnt_next;
            overflow_out <= overflow_out || drop;
            valid_out    <= (wr_ptr_next != rd_ptr_next);
            data_out     <= data_next;
        end
    end

    // Storage array; contents are not reset.
    always_ff @(posedge clk) begin
        if (!rst && !clear_in && push) begin
            mem[wr_ptr[AW-1:0]] <= data_in;
        end
    end

endmodule

// File: tb/tb_fir_output_buffer.sv
// Scoreboard bench for fir_output_buffer: stimulus queues expected samples,
// a negedge monitor pops and compares whenever the output handshake fires.
module tb_fir_output_buffer;

    localparam int unsigned DATABITS = 16;
    localparam int unsigned DEPTH    = 8;
    localparam int unsigned DECIMW   = 4;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [DATABITS-1:0]    data_in;
    logic                   data_valid_in;
    logic [DECIMW-1:0]      decim_in;
    logic                   clear_in;
    logic                   ready_in;
    logic [DATABITS-1:0]    data_out;
    logic                   valid_out;
    logic [$clog2(DEPTH):0] level_out;
    logic                   overflow_out;

    int total = 0;
    int bad   = 0;
    int q[$];

    fir_output_buffer #(.DATABITS(DATABITS), .DEPTH(DEPTH), .DECIMW(DECIMW)) dut (
        .clk          (clk),
        .rst          (rst),
        .data_in      (data_in),
        .data_valid_in(data_valid_in),
        .decim_in     (decim_in),
        .clear_in     (clear_in),
        .ready_in     (ready_in),
        .data_out     (data_out),
        .valid_out    (valid_out),
        .level_out    (level_out),
        .overflow_out (overflow_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s act=%0d exp=%0d", name, act, exp);
        end
    endtask

    // Monitor: a transfer happens at the next rising edge when valid & ready.
    always @(negedge clk) begin
        if (!rst && !clear_in && valid_out && ready_in) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_out act=%0d exp=none", data_out);
            end else begin
                chk("data_out", int'(data_out), q.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input int v, input bit exp_kept);
        data_in       = DATABITS'(v);
        data_valid_in = 1'b1;
        if (exp_kept) q.push_back(v);
        step();
        data_valid_in = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        ready_in = 1'b1;
        while ((q.size() != 0 || valid_out) && n < 60) begin
            step();
            n++;
        end
        chk("drain_done", int'(n < 60), 1);
    endtask

    initial begin
        int exp_level;
        int sent;
        int cyc;
        bit pop_m;
        bit can;

        rst = 1'b1; data_in = '0; data_valid_in = 1'b0; decim_in = 4'd1;
        clear_in = 1'b0; ready_in = 1'b0;
        repeat (3) step();
        chk("rst_valid", int'(valid_out), 0);
        chk("rst_data", int'(data_out), 0);
        chk("rst_level", int'(level_out), 0);
        chk("rst_ovf", int'(overflow_out), 0);
        rst = 1'b0;
        step();

        // Pass-through: one-cycle latency, level never above 1.
        ready_in = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            strobe(i, 1'b1);
            chk("pt_valid", int'(valid_out), 1);
            chk("pt_level", int'(level_out), 1);
        end
        drain();
        chk("pt_level_end", int'(level_out), 0);

        // Decimation by 3, then factor 0 acting as 1.
        decim_in = 4'd3;
        for (int i = 10; i <= 18; i++) strobe(i, (i == 10 || i == 13 || i == 16));
        drain();
        decim_in = 4'd0;
        for (int i = 20; i <= 23; i++) strobe(i, 1'b1);
        drain();
        decim_in = 4'd1;

        // Fill and overflow, sticky until clear.
        ready_in = 1'b0;
        for (int i = 100; i <= 107; i++) strobe(i, 1'b1);
        chk("fill_level", int'(level_out), 8);
        chk("fill_ovf", int'(overflow_out), 0);
        strobe(108, 1'b0);
        chk("ovf_set", int'(overflow_out), 1);
        chk("ovf_level", int'(level_out), 8);
        strobe(109, 1'b0);
        drain();
        chk("ovf_sticky", int'(overflow_out), 1);
        chk("ovf_drained_level", int'(level_out), 0);
        clear_in = 1'b1;
        step();
        clear_in = 1'b0;
        chk("ovf_cleared", int'(overflow_out), 0);

        // Full with simultaneous push and pop.
        ready_in = 1'b0;
        for (int i = 200; i <= 207; i++) strobe(i, 1'b1);
        chk("full_level", int'(level_out), 8);
        ready_in = 1'b1;
        strobe(208, 1'b1);
        chk("fullpp_level", int'(level_out), 8);
        chk("fullpp_ovf", int'(overflow_out), 0);
        drain();

        // Wrap-around with random backpressure; only strobe when a push fits.
        exp_level = 0;
        sent = 0;
        cyc = 0;
        while (sent < 3 * DEPTH + 3 && cyc < 400) begin
            ready_in = 1'($urandom_range(0, 1));
            pop_m = (exp_level != 0) && ready_in;
            can = (exp_level < DEPTH) || pop_m;
            if (can) begin
                data_in = DATABITS'(500 + sent);
                data_valid_in = 1'b1;
                q.push_back(500 + sent);
                sent++;
            end
            step();
            data_valid_in = 1'b0;
            exp_level = exp_level + int'(can) - int'(pop_m);
            chk("wrap_level", int'(level_out), exp_level);
            cyc++;
        end
        chk("wrap_sent", sent, 3 * DEPTH + 3);
        drain();
        chk("wrap_ovf", int'(overflow_out), 0);

        // Clear at level 5 with a coincident strobe that must vanish.
        ready_in = 1'b0;
        for (int i = 300; i <= 304; i++) strobe(i, 1'b1);
        chk("clr_pre_level", int'(level_out), 5);
        clear_in = 1'b1;
        strobe(305, 1'b0);
        clear_in = 1'b0;
        q.delete();
        chk("clr_valid", int'(valid_out), 0);
        chk("clr_level", int'(level_out), 0);
        ready_in = 1'b1;
        repeat (3) step();
        chk("clr_idle_valid", int'(valid_out), 0);
        strobe(310, 1'b1);
        drain();

        // Reset while busy.
        ready_in = 1'b0;
        for (int i = 400; i <= 402; i++) strobe(i, 1'b1);
        chk("busy_level", int'(level_out), 3);
        rst = 1'b1;
        step();
        q.delete();
        chk("brst_valid", int'(valid_out), 0);
        chk("brst_data", int'(data_out), 0);
        chk("brst_level", int'(level_out), 0);
        chk("brst_ovf", int'(overflow_out), 0);
        rst = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fir_output_buffer.md
Name: fir_output_buffer

Overview:
- Output stage placed directly downstream of the FIR filter top.
- Consumes the filter's sample stream (data_out/data_valid_out), decimates it by a runtime factor, and buffers the kept samples in a small FIFO.
- Presents them to the next consumer over a valid/ready handshake.
- Flags lost samples with a sticky overflow bit.

Parameters:
DATABITS, 16, sample width; equals filter output width
DEPTH, 8, FIFO entries; power of two, >= 2
DECIMW, 4, width of decimation factor input

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
data_in  in  DATABITS  filter output sample
data_valid_in  in  1  one-cycle strobe, data_in valid
decim_in  in  DECIMW  decimation factor N; keep 1 of every N samples; 0 treated as 1
clear_in  in  1  synchronous flush
ready_in  in  1  downstream ready
data_out  out  DATABITS  head-of-FIFO sample
valid_out  out  1  data_out valid
level_out  out  $clog2(DEPTH)+1  current FIFO occupancy
overflow_out  out  1  sticky, a kept sample was dropped

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous, active-high; sampled only on rising clk.
- Reset values:
  - valid_out=0, data_out=0, level_out=0, overflow_out=0.
  - Decimation counter=0; read/write pointers=0.
  - Memory contents are not reset.
- Decimation:
  - eff = (decim_in==0) ? 1 : decim_in.
  - On each data_valid_in, the sample is kept iff cnt==0.
  - cnt_next = (cnt+1 >= eff) ? 0 : cnt+1.
  - cnt is unchanged on cycles without data_valid_in.
  - Lowering decim_in mid-run wraps cnt at the next strobe via the >= compare; no out-of-range state.
- Handshake:
  - pop = valid_out & ready_in.
  - push = kept & (!full | pop).
- FIFO:
  - First-word-fall-through. valid_out = !empty.
  - data_out = mem[rd_ptr] when valid_out, else 0.
  - Pointers are $clog2(DEPTH)+1 bits. full when MSBs differ and remaining bits are equal; empty when pointers are equal.
- Latency:
  - A sample kept at edge k appears on data_out with valid_out=1 after edge k (1 cycle).
  - No same-cycle bypass when empty.
- Simultaneous push and pop:
  - Empty: only push is effective (pop is impossible since valid_out=0).
  - Full: both execute, level unchanged, no overflow.
  - Otherwise: level unchanged, both pointers advance.
- Overflow: a kept sample while full and !pop is dropped and overflow_out is set. It stays set until clear_in or rst.
- level_out: registered. Updates on the same edge as the pointers: +1 on push only, -1 on pop only.
- Pointer wrap: modulo 2*DEPTH. Occupancy is correct across any number of wraps.
- clear_in:
  - Priority: rst > clear_in > push/pop.
  - Resets pointers, level, cnt and overflow_out. A data_valid_in in the same cycle is discarded.
  - valid_out=0 on the next cycle.
- data_valid_in while rst or clear_in is asserted is ignored.

Test Plan:
- Basic pass-through: decim_in=1, ready_in=1, push 0x0001..0x0005 on consecutive cycles -> data_out 0x0001..0x0005 each one cycle after input, valid_out high 5 cycles, level_out never exceeds 1.
- Decimation: decim_in=3, 9 strobes with values 10..18 -> output exactly 10, 13, 16. Test decim_in=0 -> every sample kept.
- Fill and overflow: ready_in=0, DEPTH=8, push 10 samples -> level_out=8, overflow_out=1 after the 9th. Drain yields the first 8 samples in order, and overflow_out stays 1 until clear_in.
- Full plus simultaneous pop: fill to 8, then ready_in=1 with a push in the same cycle -> level_out stays 8, overflow_out=0, order preserved.
- Wrap-around: 3*DEPTH+3 samples with random ready_in -> scoreboard matches input order; level_out consistent with pushes minus pops.
- Clear and reset mid-stream:
  - clear_in while level_out=5 with a coincident strobe -> next cycle valid_out=0, level_out=0, and the strobed sample never appears.
  - rst asserted while busy -> all outputs at reset values.
